// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module  : free_list_pkg
// Brief   : Shared sizes, the tag type and helper functions for the R10K
//           free list.
// Rev     : 1.0  initial release
// ============================================================================
package free_list_pkg;

  localparam int SS_SIZE      = 2;
  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int TAG_W        = $clog2(NUM_PHYS_REG);
  // Pointers carry one extra wrap bit above the table index.
  localparam int PTR_W        = $clog2(FL_SIZE) + 1;
  localparam int IDX_W        = PTR_W - 1;
  // Enough bits to hold a count of 0..SS_SIZE set lanes.
  localparam int RANK_W       = $clog2(SS_SIZE + 1);

  typedef logic [TAG_W-1:0] PHYS_REG;

  // Tag reported on a lane that did not allocate.
  localparam PHYS_REG DUMMY_REG = '0;

  // Population count of a lane vector.
  function automatic logic [RANK_W-1:0] BIT_COUNT_LUT(input logic [SS_SIZE-1:0] v);
    logic [RANK_W-1:0] n;
    n = '0;
    for (int i = 0; i < SS_SIZE; i++) begin
      n = n + RANK_W'(v[i]);
    end
    return n;
  endfunction

  // Table slot addressed by a pointer (wrap bit dropped).
  function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
    return p[IDX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module  : free_list_if
// Brief   : Dispatch / retire / recovery bundle between the rename stage and
//           the free list.
// Rev     : 1.0  initial release
// ============================================================================
interface free_list_if;
  import free_list_pkg::*;

  logic                           flush;
  logic [SS_SIZE-1:0]             alloc_req;
  logic [SS_SIZE-1:0][TAG_W-1:0]  alloc_tag;
  logic                           alloc_ok;
  logic                           stall;
  logic [SS_SIZE-1:0]             free_en;
  logic [SS_SIZE-1:0][TAG_W-1:0]  free_tag;
  logic [SS_SIZE-1:0]             commit_en;
  logic [PTR_W-1:0]               free_count;
  logic                           empty;

  // Rename / ROB side.
  modport master (
    output flush, alloc_req, free_en, free_tag, commit_en,
    input  alloc_tag, alloc_ok, stall, free_count, empty
  );

  // Free list side.
  modport slave (
    input  flush, alloc_req, free_en, free_tag, commit_en,
    output alloc_tag, alloc_ok, stall, free_count, empty
  );

endinterface
`default_nettype wire

// File: rtl/free_list_lane_rank.sv
`default_nettype none
// ============================================================================
// Module  : free_list_lane_rank
// Brief   : Prefix popcount: offset of each set lane among the set lanes,
//           counting from the oldest (highest-numbered) lane, plus the total.
// Rev     : 1.0  initial release
// ============================================================================
module free_list_lane_rank
  import free_list_pkg::*;
(
  input  wire logic [SS_SIZE-1:0]              i_vec,
  output logic      [SS_SIZE-1:0][RANK_W-1:0]  o_rank,
  output logic      [RANK_W-1:0]               o_total
);

  logic [RANK_W-1:0] w_acc;

  // Walk from the oldest lane down, handing each lane the running count.
  always_comb begin
    w_acc  = '0;
    o_rank = '0;
    for (int l = SS_SIZE - 1; l >= 0; l--) begin
      o_rank[l] = w_acc;
      w_acc     = w_acc + RANK_W'(i_vec[l]);
    end
    o_total = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module  : free_list
// Brief   : Circular FIFO of free physical tags for R10K renaming. Grants up
//           to SS_SIZE tags per cycle, reclaims retired T_old tags, and keeps
//           a committed read pointer so a flush restores speculative grants.
//           Optional macro FREE_LIST_DEBUG_EN exposes the table/pointers and
//           enables simulation consistency checks.
// Rev     : 1.0  initial release
// ============================================================================
module free_list
  import free_list_pkg::*;
(
  input  wire logic                      clock,
  input  wire logic                      reset,
  free_list_if.slave                     bus
`ifdef FREE_LIST_DEBUG_EN
  ,
  output logic      [FL_SIZE*TAG_W-1:0]  fl_table_out,
  output logic      [PTR_W-1:0]          head_out,
  output logic      [PTR_W-1:0]          arch_head_out,
  output logic      [PTR_W-1:0]          tail_out
`endif
);

  PHYS_REG                        r_table [FL_SIZE];
  logic [PTR_W-1:0]               r_head;
  logic [PTR_W-1:0]               r_arch_head;
  logic [PTR_W-1:0]               r_tail;
  logic [PTR_W-1:0]               r_free_count;
  logic                           r_empty;

  logic [SS_SIZE-1:0][RANK_W-1:0] w_arank;
  logic [SS_SIZE-1:0][RANK_W-1:0] w_frank;
  logic [RANK_W-1:0]              w_n_req;
  logic [RANK_W-1:0]              w_n_free;
  logic [RANK_W-1:0]              w_n_commit;
  logic [PTR_W-1:0]               w_count;
  logic                           w_alloc_ok;
  logic [SS_SIZE-1:0][TAG_W-1:0]  w_alloc_tag;
  logic [PTR_W-1:0]               w_head_next;
  logic [PTR_W-1:0]               w_arch_next;
  logic [PTR_W-1:0]               w_tail_next;
  logic [PTR_W-1:0]               w_count_next;

  free_list_lane_rank u_alloc_rank (
    .i_vec   (bus.alloc_req),
    .o_rank  (w_arank),
    .o_total (w_n_req)
  );

  free_list_lane_rank u_free_rank (
    .i_vec   (bus.free_en),
    .o_rank  (w_frank),
    .o_total (w_n_free)
  );

  assign w_n_commit = BIT_COUNT_LUT(bus.commit_en);

  // Wrap bits make tail-head exact even when the list is completely full.
  assign w_count    = r_tail - r_head;
  // Tags freed this cycle are not counted: there is no free->alloc bypass.
  assign w_alloc_ok = (PTR_W'(w_n_req) <= w_count) & ~bus.flush;

  // All-or-nothing grant; oldest requesting lane reads table[head].
  always_comb begin
    w_alloc_tag = '0;
    for (int l = 0; l < SS_SIZE; l++) begin
      if (bus.alloc_req[l] && w_alloc_ok) begin
        w_alloc_tag[l] = r_table[ptr_idx(r_head + PTR_W'(w_arank[l]))];
      end
    end
  end

  // Flush rewinds the speculative head onto the (just updated) committed head.
  always_comb begin
    w_arch_next = r_arch_head + PTR_W'(w_n_commit);
    w_tail_next = r_tail + PTR_W'(w_n_free);
    if (bus.flush) begin
      w_head_next = w_arch_next;
    end else if (w_alloc_ok) begin
      w_head_next = r_head + PTR_W'(w_n_req);
    end else begin
      w_head_next = r_head;
    end
    w_count_next = w_tail_next - w_head_next;
  end

  // Pointer and occupancy registers; reset leaves the list full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head       <= '0;
      r_arch_head  <= '0;
      r_tail       <= PTR_W'(FL_SIZE);
      r_free_count <= PTR_W'(FL_SIZE);
      r_empty      <= 1'b0;
    end else begin
      r_head       <= w_head_next;
      r_arch_head  <= w_arch_next;
      r_tail       <= w_tail_next;
      r_free_count <= w_count_next;
      r_empty      <= (w_count_next == '0);
    end
  end

  // Retired tags land at consecutive slots from tail, oldest lane first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_table[i] <= TAG_W'(NUM_ARCH_REG + i);
      end
    end else begin
      for (int l = 0; l < SS_SIZE; l++) begin
        if (bus.free_en[l]) begin
          r_table[ptr_idx(r_tail + PTR_W'(w_frank[l]))] <= bus.free_tag[l];
        end
      end
    end
  end

  assign bus.alloc_tag  = w_alloc_tag;
  assign bus.alloc_ok   = w_alloc_ok;
  assign bus.stall      = (|bus.alloc_req) & ~w_alloc_ok;
  assign bus.free_count = r_free_count;
  assign bus.empty      = r_empty;

`ifdef FREE_LIST_DEBUG_EN
  genvar gi;
  generate
    for (gi = 0; gi < FL_SIZE; gi++) begin : g_dbg_table
      assign fl_table_out[gi*TAG_W +: TAG_W] = r_table[gi];
    end
  endgenerate

  assign head_out      = r_head;
  assign arch_head_out = r_arch_head;
  assign tail_out      = r_tail;

  // Flag illegal retire traffic the pointer arithmetic cannot detect itself.
  always @(posedge clock) begin
    if (!reset) begin
      if ((int'(w_count) + int'(w_n_free)) > FL_SIZE) begin
        $error("free_list: free while full (count=%0d freed=%0d)", w_count, w_n_free);
      end
      if ((w_head_next - w_arch_next) > PTR_W'(FL_SIZE)) begin
        $error("free_list: arch_head passed head");
      end
      for (int l = 0; l < SS_SIZE; l++) begin
        if (bus.free_en[l]) begin
          for (int k = 0; k < FL_SIZE; k++) begin
            if ((k < int'(w_count)) &&
                (r_table[ptr_idx(r_head + PTR_W'(k))] == bus.free_tag[l])) begin
              $error("free_list: tag %0d freed while already free", bus.free_tag[l]);
            end
          end
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module  : tb_free_list
// Brief   : Directed self-checking bench for free_list with a queue model of
//           the free list and a scoreboard of expected granted tags.
// Rev     : 1.0  initial release
// ============================================================================
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  free_list_if u_if ();

`ifdef FREE_LIST_DEBUG_EN
  logic [FL_SIZE*TAG_W-1:0] w_dbg_table;
  logic [PTR_W-1:0]         w_dbg_head;
  logic [PTR_W-1:0]         w_dbg_arch;
  logic [PTR_W-1:0]         w_dbg_tail;
`endif

  free_list u_dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (u_if.slave)
`ifdef FREE_LIST_DEBUG_EN
    ,
    .fl_table_out  (w_dbg_table),
    .head_out      (w_dbg_head),
    .arch_head_out (w_dbg_arch),
    .tail_out      (w_dbg_tail)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: m_q holds tags from the committed head to the tail, in order;
  // the first m_alloc of them are speculatively handed out.
  int m_q[$];
  int m_alloc;
  // Scoreboard of tags expected on the alloc lanes, oldest lane first.
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after the edge, check grants at negedge,
  // update the model at the edge, then check the registered count.
  task automatic step(input logic [1:0] req, input logic [1:0] fen,
                      input int ft1, input int ft0,
                      input logic [1:0] cen, input logic fl, input string tag);
    int  n_req;
    int  n_com;
    int  cnt;
    int  e;
    bit  ok;
    u_if.alloc_req   = req;
    u_if.free_en     = fen;
    u_if.free_tag[1] = TAG_W'(ft1);
    u_if.free_tag[0] = TAG_W'(ft0);
    u_if.commit_en   = cen;
    u_if.flush       = fl;

    cnt   = m_q.size() - m_alloc;
    n_req = int'(req[0]) + int'(req[1]);
    n_com = int'(cen[0]) + int'(cen[1]);
    ok    = (n_req <= cnt) && !fl;
    if (ok) begin
      e = m_alloc;
      for (int l = 1; l >= 0; l--) begin
        if (req[l]) begin
          exp_q.push_back(m_q[e]);
          e++;
        end
      end
    end

    @(negedge clock);
    check({tag, ".alloc_ok"}, 32'(u_if.alloc_ok), 32'(ok));
    check({tag, ".stall"}, 32'(u_if.stall), 32'((req != 2'b00) && !ok));
    for (int l = 1; l >= 0; l--) begin
      if (ok && req[l]) begin
        check($sformatf("%s.tag%0d", tag, l), 32'(u_if.alloc_tag[l]), 32'(exp_q.pop_front()));
      end else begin
        check($sformatf("%s.tag%0d_idle", tag, l), 32'(u_if.alloc_tag[l]), 32'd0);
      end
    end

    @(posedge clock);
    if (ok) m_alloc += n_req;
    repeat (n_com) begin
      m_q.delete(0);
      m_alloc--;
    end
    if (fl) m_alloc = 0;
    if (fen[1]) m_q.push_back(ft1);
    if (fen[0]) m_q.push_back(ft0);
    #1;
    check({tag, ".free_count"}, 32'(u_if.free_count), 32'(m_q.size() - m_alloc));
    check({tag, ".empty"}, 32'(u_if.empty), 32'((m_q.size() - m_alloc) == 0));
  endtask

  // Hard stop in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    u_if.flush     = 1'b0;
    u_if.alloc_req = '0;
    u_if.free_en   = '0;
    u_if.free_tag  = '0;
    u_if.commit_en = '0;
    for (int i = 0; i < FL_SIZE; i++) m_q.push_back(NUM_ARCH_REG + i);
    m_alloc = 0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst.free_count", 32'(u_if.free_count), 32'(FL_SIZE));
    check("rst.empty", 32'(u_if.empty), 32'd0);
    check("rst.alloc_ok", 32'(u_if.alloc_ok), 32'd1);
    check("rst.stall", 32'(u_if.stall), 32'd0);
    check("rst.tag1", 32'(u_if.alloc_tag[1]), 32'd0);
    check("rst.tag0", 32'(u_if.alloc_tag[0]), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: drain the full list two tags at a time, then stall when empty.
    repeat (FL_SIZE / 2) step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t1_alloc");
    step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t1_stall");
    step(2'b01, 2'b00, 0, 0, 2'b00, 1'b0, "t1_stall1");

    // 2: one free entry: a two-lane request is refused, one lane succeeds.
    step(2'b00, 2'b10, 40, 0, 2'b00, 1'b0, "t2_free");
    step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t2_stall");
    step(2'b10, 2'b00, 0, 0, 2'b00, 1'b0, "t2_grant");

    // 3: a tag freed this cycle is only allocatable next cycle.
    step(2'b01, 2'b01, 0, 5, 2'b00, 1'b0, "t3_nobypass");
    step(2'b01, 2'b00, 0, 0, 2'b00, 1'b0, "t3_next");

    // 4: commit everything, refill, allocate 6, commit 2, flush, reissue 4.
    repeat (17) step(2'b00, 2'b00, 0, 0, 2'b11, 1'b0, "t4_commit");
    for (int i = 0; i < 4; i++) step(2'b00, 2'b11, 50 + 2*i, 51 + 2*i, 2'b00, 1'b0, "t4_refill");
    repeat (3) step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t4_alloc");
    step(2'b00, 2'b00, 0, 0, 2'b11, 1'b0, "t4_commit2");
    step(2'b00, 2'b00, 0, 0, 2'b00, 1'b1, "t4_flush");
    repeat (2) step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t4_reissue");

    // 5: flush together with a commit, a free and an alloc request.
    step(2'b11, 2'b01, 0, 20, 2'b01, 1'b1, "t5_flush");
    step(2'b11, 2'b00, 0, 0, 2'b00, 1'b0, "t5_after");
    step(2'b00, 2'b00, 0, 0, 2'b11, 1'b0, "t5_commit");

    // 6: sustained 2-in/2-out traffic across several pointer wraps.
    for (int i = 0; i < 3 * FL_SIZE; i++) begin
      step(2'b11, 2'b11, 1 + (i * 7) % 62, 2 + (i * 11) % 61, 2'b11, 1'b0, "t6_stream");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
